// File: rtl/dmem_channel_arbiter.sv
// Data-memory channel arbiter: shares NUM_CHANNELS memory channels among NUM_CONSUMERS LSU ports.
// Latency: 3 cycles from the consumer valid edge to the registered consumer ready, with zero-wait memory.
// Backpressure: a consumer holds valid until it sees ready; a channel holds its mem request until mem ready.
module dmem_channel_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

  // Per-channel transaction context
  state_t               state_q   [NUM_CHANNELS];
  state_t               state_d   [NUM_CHANNELS];
  logic [CW-1:0]        owner_q   [NUM_CHANNELS];
  logic [CW-1:0]        owner_d   [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] addr_q    [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] addr_d    [NUM_CHANNELS];
  logic [DATA_BITS-1:0] wdata_q   [NUM_CHANNELS];
  logic [DATA_BITS-1:0] wdata_d   [NUM_CHANNELS];
  logic [DATA_BITS-1:0] rdata_q   [NUM_CHANNELS];
  logic [DATA_BITS-1:0] rdata_d   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] is_read_q, is_read_d;
  logic [NUM_CHANNELS-1:0] abandon_q, abandon_d;
  logic [NUM_CHANNELS-1:0] owner_valid;

  logic [NUM_CONSUMERS-1:0] owned_q, owned_d;
  logic [NUM_CONSUMERS-1:0] pending;
  logic [CW-1:0]            rr_ptr_q, rr_ptr_d;

  // Next values of the registered outputs
  logic [NUM_CHANNELS-1:0]            mem_read_valid_d, mem_write_valid_d;
  logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address_d, mem_write_address_d;
  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data_d;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready_d, consumer_write_ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data_d;

  assign pending = (consumer_read_valid | consumer_write_valid) & ~owned_q;

  // Whether each channel's owner still requests the kind of access the channel is serving
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      owner_valid[c] = is_read_q[c] ? consumer_read_valid[owner_q[c]]
                                    : consumer_write_valid[owner_q[c]];
    end
  end

  // Channel FSMs and claim arbitration; lower channels pick first, each from rr_ptr onward
  always_comb begin
    logic [NUM_CONSUMERS-1:0] taken;
    logic                     found;
    int                       k;
    taken    = '0;
    found    = 1'b0;
    k        = 0;
    owned_d  = owned_q;
    rr_ptr_d = rr_ptr_q;
    is_read_d = is_read_q;
    abandon_d = abandon_q;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      state_d[c] = state_q[c];
      owner_d[c] = owner_q[c];
      addr_d[c]  = addr_q[c];
      wdata_d[c] = wdata_q[c];
      rdata_d[c] = rdata_q[c];
      case (state_q[c])
        IDLE: begin
          found = 1'b0;
          for (int i = 0; i < NUM_CONSUMERS; i++) begin
            k = (int'(rr_ptr_q) + i) % NUM_CONSUMERS;
            if (!found && pending[k] && !taken[k]) begin
              found        = 1'b1;
              taken[k]     = 1'b1;
              owned_d[k]   = 1'b1;
              owner_d[c]   = CW'(k);
              wdata_d[c]   = consumer_write_data[k*DATA_BITS +: DATA_BITS];
              abandon_d[c] = 1'b0;
              rr_ptr_d     = CW'((k + 1) % NUM_CONSUMERS);
              // Read wins when a consumer raises both; the write is re-claimed afterwards
              if (consumer_read_valid[k]) begin
                is_read_d[c] = 1'b1;
                addr_d[c]    = consumer_read_address[k*ADDR_BITS +: ADDR_BITS];
                state_d[c]   = READ_WAIT;
              end else begin
                is_read_d[c] = 1'b0;
                addr_d[c]    = consumer_write_address[k*ADDR_BITS +: ADDR_BITS];
                state_d[c]   = WRITE_WAIT;
              end
            end
          end
        end
        READ_WAIT, WRITE_WAIT: begin
          // A dropped valid never aborts the memory access; it only discards the response
          if (!owner_valid[c]) abandon_d[c] = 1'b1;
          if ((state_q[c] == READ_WAIT) ? mem_read_ready[c] : mem_write_ready[c]) begin
            if (abandon_q[c] || !owner_valid[c]) begin
              state_d[c]          = IDLE;
              owned_d[owner_q[c]] = 1'b0;
            end else begin
              state_d[c] = RELAY;
              rdata_d[c] = mem_read_data[c*DATA_BITS +: DATA_BITS];
            end
          end
        end
        RELAY: begin
          if (!owner_valid[c]) begin
            state_d[c]          = IDLE;
            owned_d[owner_q[c]] = 1'b0;
          end
        end
        default: state_d[c] = IDLE;
      endcase
    end
  end

  // Output next values; unused address/data lanes are forced to zero
  always_comb begin
    mem_read_valid_d       = '0;
    mem_read_address_d     = '0;
    mem_write_valid_d      = '0;
    mem_write_address_d    = '0;
    mem_write_data_d       = '0;
    consumer_read_ready_d  = '0;
    consumer_read_data_d   = '0;
    consumer_write_ready_d = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (state_d[c] == READ_WAIT) begin
        mem_read_valid_d[c]                          = 1'b1;
        mem_read_address_d[c*ADDR_BITS +: ADDR_BITS] = addr_d[c];
      end
      if (state_d[c] == WRITE_WAIT) begin
        mem_write_valid_d[c]                          = 1'b1;
        mem_write_address_d[c*ADDR_BITS +: ADDR_BITS] = addr_d[c];
        mem_write_data_d[c*DATA_BITS +: DATA_BITS]    = wdata_d[c];
      end
      if (state_q[c] == RELAY && owner_valid[c]) begin
        if (is_read_q[c]) begin
          consumer_read_ready_d[owner_q[c]]                             = 1'b1;
          consumer_read_data_d[int'(owner_q[c])*DATA_BITS +: DATA_BITS] = rdata_q[c];
        end else begin
          consumer_write_ready_d[owner_q[c]] = 1'b1;
        end
      end
    end
  end

  // State and output registers, all cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= IDLE;
        owner_q[c] <= '0;
        addr_q[c]  <= '0;
        wdata_q[c] <= '0;
        rdata_q[c] <= '0;
      end
      is_read_q            <= '0;
      abandon_q            <= '0;
      owned_q              <= '0;
      rr_ptr_q             <= '0;
      mem_read_valid       <= '0;
      mem_read_address     <= '0;
      mem_write_valid      <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        owner_q[c] <= owner_d[c];
        addr_q[c]  <= addr_d[c];
        wdata_q[c] <= wdata_d[c];
        rdata_q[c] <= rdata_d[c];
      end
      is_read_q            <= is_read_d;
      abandon_q            <= abandon_d;
      owned_q              <= owned_d;
      rr_ptr_q             <= rr_ptr_d;
      mem_read_valid       <= mem_read_valid_d;
      mem_read_address     <= mem_read_address_d;
      mem_write_valid      <= mem_write_valid_d;
      mem_write_address    <= mem_write_address_d;
      mem_write_data       <= mem_write_data_d;
      consumer_read_ready  <= consumer_read_ready_d;
      consumer_read_data   <= consumer_read_data_d;
      consumer_write_ready <= consumer_write_ready_d;
    end
  end

endmodule

// File: tb/tb_dmem_channel_arbiter.sv
// Directed bench for dmem_channel_arbiter with a zero-wait memory responder (read data = addr ^ 0x76).
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
// Per-channel read stall mask lets a test hold mem_read_ready low.
module tb_dmem_channel_arbiter;

  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int NCS = 8;
  localparam int NCH = 4;

  logic               clk;
  logic               reset;
  logic [NCS-1:0]     consumer_read_valid;
  logic [NCS*AB-1:0]  consumer_read_address;
  logic [NCS-1:0]     consumer_read_ready;
  logic [NCS*DB-1:0]  consumer_read_data;
  logic [NCS-1:0]     consumer_write_valid;
  logic [NCS*AB-1:0]  consumer_write_address;
  logic [NCS*DB-1:0]  consumer_write_data;
  logic [NCS-1:0]     consumer_write_ready;
  logic [NCH-1:0]     mem_read_valid;
  logic [NCH*AB-1:0]  mem_read_address;
  logic [NCH-1:0]     mem_read_ready;
  logic [NCH*DB-1:0]  mem_read_data;
  logic [NCH-1:0]     mem_write_valid;
  logic [NCH*AB-1:0]  mem_write_address;
  logic [NCH*DB-1:0]  mem_write_data;
  logic [NCH-1:0]     mem_write_ready;
  logic [NCH-1:0]     rd_stall;

  int checks = 0;
  int errors = 0;

  dmem_channel_arbiter #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NCS), .NUM_CHANNELS(NCH)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (consumer_read_valid),
    .consumer_read_address  (consumer_read_address),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (consumer_write_valid),
    .consumer_write_address (consumer_write_address),
    .consumer_write_data    (consumer_write_data),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait memory: ready follows valid unless the channel is stalled
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      mem_read_ready[c]           = mem_read_valid[c] & ~rd_stall[c];
      mem_read_data[c*DB +: DB]   = mem_read_address[c*AB +: AB] ^ 8'h76;
      mem_write_ready[c]          = mem_write_valid[c];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    consumer_read_valid    = '0;
    consumer_read_address  = '0;
    consumer_write_valid   = '0;
    consumer_write_address = '0;
    consumer_write_data    = '0;
    rd_stall               = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic rd_req(input int k, input logic [7:0] a);
    consumer_read_valid[k]           = 1'b1;
    consumer_read_address[k*AB +: AB] = a;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    #3;
    check("reset_mem_rv",  64'(mem_read_valid), 64'h0);
    check("reset_mem_wv",  64'(mem_write_valid), 64'h0);
    check("reset_cons_rr", 64'(consumer_read_ready), 64'h0);
    check("reset_cons_wr", 64'(consumer_write_ready), 64'h0);
    check("reset_mem_ra",  64'(mem_read_address), 64'h0);
    check("reset_cons_rd", consumer_read_data, 64'h0);

    // Single read: consumer 3, addr 0x2A -> data 0x5C
    do_reset();
    rd_req(3, 8'h2A);
    tick();
    check("single_mem_rv", 64'(mem_read_valid), 64'h1);
    check("single_mem_ra", 64'(mem_read_address), 64'h2A);
    check("single_rr_e1",  64'(consumer_read_ready), 64'h0);
    tick();
    check("single_mem_rv_drop", 64'(mem_read_valid), 64'h0);
    check("single_rr_e2",  64'(consumer_read_ready), 64'h0);
    tick();
    check("single_rr",     64'(consumer_read_ready), 64'h08);
    check("single_rd",     consumer_read_data, 64'h5C00_0000);
    consumer_read_valid[3] = 1'b0;
    tick();
    check("single_rr_clear", 64'(consumer_read_ready), 64'h0);
    check("single_rd_clear", consumer_read_data, 64'h0);

    // Saturation: all eight consumers read at once
    do_reset();
    for (int k = 0; k < NCS; k++) rd_req(k, 8'(8'h10 + k));
    tick();
    check("sat_mem_rv_a", 64'(mem_read_valid), 64'hF);
    check("sat_mem_ra_a", 64'(mem_read_address), 64'h1312_1110);
    tick();
    check("sat_mem_rv_drop", 64'(mem_read_valid), 64'h0);
    tick();
    check("sat_rr_a", 64'(consumer_read_ready), 64'h0F);
    check("sat_rd_a", consumer_read_data, 64'h0000_0000_6564_6766);
    consumer_read_valid[3:0] = 4'h0;
    tick();
    check("sat_rr_gap", 64'(consumer_read_ready), 64'h0);
    rd_req(0, 8'h20);
    tick();
    check("sat_mem_rv_b", 64'(mem_read_valid), 64'hF);
    check("sat_mem_ra_b", 64'(mem_read_address), 64'h1716_1514);
    tick();
    tick();
    check("sat_rr_b", 64'(consumer_read_ready), 64'hF0);
    check("sat_rd_b", consumer_read_data, 64'h6160_6362_0000_0000);
    consumer_read_valid[7:4] = 4'h0;
    tick();
    check("sat_rr_gap2", 64'(consumer_read_ready), 64'h0);
    tick();
    check("sat_mem_rv_c", 64'(mem_read_valid), 64'h1);
    check("sat_mem_ra_c", 64'(mem_read_address), 64'h20);
    tick();
    tick();
    check("sat_rr_c", 64'(consumer_read_ready), 64'h01);
    check("sat_rd_c", consumer_read_data, 64'h56);
    consumer_read_valid[0] = 1'b0;
    tick();
    check("sat_rr_end", 64'(consumer_read_ready), 64'h0);

    // Read/write collision on consumer 1
    do_reset();
    rd_req(1, 8'h31);
    consumer_write_valid[1]       = 1'b1;
    consumer_write_address[15:8]  = 8'h41;
    consumer_write_data[15:8]     = 8'hAB;
    tick();
    check("coll_mem_rv", 64'(mem_read_valid), 64'h1);
    check("coll_mem_ra", 64'(mem_read_address), 64'h31);
    check("coll_mem_wv_early", 64'(mem_write_valid), 64'h0);
    tick();
    tick();
    check("coll_rr", 64'(consumer_read_ready), 64'h02);
    check("coll_wr_early", 64'(consumer_write_ready), 64'h0);
    check("coll_rd", consumer_read_data, 64'h4700);
    consumer_read_valid[1] = 1'b0;
    tick();
    check("coll_rr_clear", 64'(consumer_read_ready), 64'h0);
    check("coll_mem_wv_gap", 64'(mem_write_valid), 64'h0);
    tick();
    check("coll_mem_wv", 64'(mem_write_valid), 64'h1);
    check("coll_mem_wa", 64'(mem_write_address), 64'h41);
    check("coll_mem_wd", 64'(mem_write_data), 64'hAB);
    tick();
    check("coll_mem_wv_drop", 64'(mem_write_valid), 64'h0);
    tick();
    check("coll_wr", 64'(consumer_write_ready), 64'h02);
    consumer_write_valid[1] = 1'b0;
    tick();
    check("coll_wr_clear", 64'(consumer_write_ready), 64'h0);

    // Memory stall on channel 0 for 10 cycles; consumer 5 served by channel 1 meanwhile
    do_reset();
    rd_stall = 4'b0001;
    rd_req(2, 8'h5A);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("stall_rv0", 64'(mem_read_valid[0]), 64'h1);
      check("stall_ra0", 64'(mem_read_address[7:0]), 64'h5A);
      if (i == 2) rd_req(5, 8'h6B);
      if (i == 3) check("stall_ch1_claim", 64'(mem_read_address), 64'h6B5A);
      if (i == 5) begin
        check("stall_rr5", 64'(consumer_read_ready), 64'h20);
        check("stall_rd5", consumer_read_data, 64'h0000_1D00_0000_0000);
        consumer_read_valid[5] = 1'b0;
      end
      if (i == 6) check("stall_rr5_clear", 64'(consumer_read_ready), 64'h0);
    end
    rd_stall = '0;
    tick();
    check("stall_rv_drop", 64'(mem_read_valid), 64'h0);
    tick();
    check("stall_rr2", 64'(consumer_read_ready), 64'h04);
    check("stall_rd2", consumer_read_data, 64'h2C_0000);
    consumer_read_valid[2] = 1'b0;
    tick();
    check("stall_rr2_clear", 64'(consumer_read_ready), 64'h0);

    // Abandon: consumer 6 drops read_valid while channel 0 is stalled
    do_reset();
    rd_stall = 4'b0001;
    rd_req(6, 8'h77);
    tick();
    check("ab_mem_rv", 64'(mem_read_valid), 64'h1);
    tick();
    consumer_read_valid[6] = 1'b0;
    tick();
    check("ab_mem_rv_held", 64'(mem_read_valid), 64'h1);
    check("ab_mem_ra_held", 64'(mem_read_address), 64'h77);
    rd_stall = '0;
    tick();
    check("ab_mem_rv_drop", 64'(mem_read_valid), 64'h0);
    check("ab_rr_e4", 64'(consumer_read_ready), 64'h0);
    rd_req(1, 8'h22);
    tick();
    check("ab_rr_e5", 64'(consumer_read_ready), 64'h0);
    check("ab_ch0_idle_claim", 64'(mem_read_valid), 64'h1);
    check("ab_ch0_addr", 64'(mem_read_address), 64'h22);
    tick();
    tick();
    check("ab_rr1", 64'(consumer_read_ready), 64'h02);
    check("ab_rd1", consumer_read_data, 64'h5400);
    consumer_read_valid[1] = 1'b0;
    tick();

    // Reset mid-transaction: outputs clear without a clock edge
    do_reset();
    rd_stall = 4'b0001;
    rd_req(0, 8'h99);
    rd_req(4, 8'h44);
    tick();
    check("rst_mem_rv", 64'(mem_read_valid), 64'h3);
    check("rst_mem_ra", 64'(mem_read_address), 64'h4499);
    tick();
    tick();
    check("rst_rr_before", 64'(consumer_read_ready), 64'h10);
    check("rst_rd_before", consumer_read_data, 64'h32_0000_0000);
    reset = 1'b0;
    #2;
    check("rst_async_mem_rv", 64'(mem_read_valid), 64'h0);
    check("rst_async_mem_ra", 64'(mem_read_address), 64'h0);
    check("rst_async_rr", 64'(consumer_read_ready), 64'h0);
    check("rst_async_rd", consumer_read_data, 64'h0);
    clear_inputs();
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_resp", 64'(consumer_read_ready), 64'h0);
      check("rst_no_mem", 64'(mem_read_valid), 64'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
